// File: rtl/arch_loader_pkg.sv
// Shared types and index helpers for the architectural-state loader.
// The per-hart table layout is: XPR x1.., FPR f0.., CSRs, PC last.
package arch_loader_pkg;

  localparam int REG_NUM_W = 12;

  typedef enum logic [1:0] {
    WR_XPR = 2'd0,
    WR_FPR = 2'd1,
    WR_CSR = 2'd2,
    WR_PC  = 2'd3
  } wr_kind_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  typedef struct packed {
    wr_kind_e               kind;
    logic [REG_NUM_W-1:0]   num;
  } kind_num_t;

  function automatic int entries_per_hart(input int num_xpr, input int num_fpr,
                                          input int num_csr);
    return (num_xpr - 1) + num_fpr + num_csr + 1;
  endfunction

  // For CSR entries num is the slot number; the real address comes with the data.
  function automatic kind_num_t kind_of_idx(input int idx, input int num_xpr,
                                            input int num_fpr, input int num_csr);
    kind_num_t res;
    res.kind = WR_PC;
    res.num  = '0;
    if (idx < num_xpr - 1) begin
      res.kind = WR_XPR;
      res.num  = REG_NUM_W'(idx + 1);
    end else if (idx < num_xpr - 1 + num_fpr) begin
      res.kind = WR_FPR;
      res.num  = REG_NUM_W'(idx - (num_xpr - 1));
    end else if (idx < num_xpr - 1 + num_fpr + num_csr) begin
      res.kind = WR_CSR;
      res.num  = REG_NUM_W'(idx - (num_xpr - 1 + num_fpr));
    end
    return res;
  endfunction

endpackage

// File: rtl/arch_loader_idx_seq.sv
// Hart/entry sequencer: walks the state table, skipping the FPR block of
// harts whose FP unit is off, and decodes each index into kind and register.
module arch_loader_idx_seq
  import arch_loader_pkg::*;
#(
  parameter  int NUM_HARTS  = 1,
  parameter  int NUM_XPR    = 32,
  parameter  int NUM_FPR    = 32,
  parameter  int NUM_CSR    = 16,
  parameter  int CSR_ADDR_W = 12,
  localparam int ENTRIES    = entries_per_hart(NUM_XPR, NUM_FPR, NUM_CSR),
  localparam int HART_W     = $clog2(NUM_HARTS) + 1,
  localparam int IDX_W      = $clog2(ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic [NUM_HARTS-1:0]  i_fp_en,
  output logic [HART_W-1:0]     o_hart,
  output logic [IDX_W-1:0]      o_idx,
  output wr_kind_e              o_kind,
  output logic [CSR_ADDR_W-1:0] o_reg_num,
  output logic                  o_last
);

  localparam int LAST_XPR_IDX  = NUM_XPR - 2;
  localparam int FIRST_CSR_IDX = NUM_XPR - 1 + NUM_FPR;

  logic [HART_W-1:0] r_hart;
  logic [IDX_W-1:0]  r_idx;
  logic              w_fp_cur;
  logic              w_idx_last;
  logic              w_hart_last;
  kind_num_t         w_kn;

  always_comb begin
    w_fp_cur = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (r_hart == HART_W'(h)) w_fp_cur = i_fp_en[h];
    end
  end

  assign w_idx_last  = (r_idx == IDX_W'(ENTRIES - 1));
  assign w_hart_last = (r_hart == HART_W'(NUM_HARTS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hart <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_hart <= '0;
      r_idx  <= '0;
    end else if (i_advance) begin
      if (w_idx_last) begin
        r_idx  <= '0;
        r_hart <= r_hart + 1'b1;
      end else if (r_idx == IDX_W'(LAST_XPR_IDX) && !w_fp_cur) begin
        r_idx  <= IDX_W'(FIRST_CSR_IDX);
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  always_comb w_kn = kind_of_idx(int'(r_idx), NUM_XPR, NUM_FPR, NUM_CSR);

  assign o_hart    = r_hart;
  assign o_idx     = r_idx;
  assign o_kind    = w_kn.kind;
  assign o_reg_num = CSR_ADDR_W'(w_kn.num);
  assign o_last    = w_idx_last && w_hart_last;

endmodule

// File: rtl/arch_state_loader.sv
// Multi-hart architectural-state loader: streams each hart's table over a
// valid/ready write port, then releases all core resets together.
// Optional watchdog: define ARCH_LOADER_TIMEOUT_EN.
module arch_state_loader
  import arch_loader_pkg::*;
#(
  parameter  int NUM_HARTS      = 1,
  parameter  int XLEN           = 64,
  parameter  int NUM_XPR        = 32,
  parameter  int NUM_FPR        = 32,
  parameter  int NUM_CSR        = 16,
  parameter  int CSR_ADDR_W     = 12,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ENTRIES        = entries_per_hart(NUM_XPR, NUM_FPR, NUM_CSR),
  localparam int HART_W         = $clog2(NUM_HARTS) + 1,
  localparam int IDX_W          = $clog2(ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [NUM_HARTS-1:0]  i_fp_en,
  output logic                  o_tbl_req_valid,
  output logic [HART_W-1:0]     o_tbl_req_hart,
  output logic [IDX_W-1:0]      o_tbl_req_idx,
  input  logic                  i_tbl_rsp_valid,
  input  logic [XLEN-1:0]       i_tbl_rsp_data,
  input  logic [CSR_ADDR_W-1:0] i_tbl_rsp_addr,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [HART_W-1:0]     o_wr_hart,
  output logic [1:0]            o_wr_kind,
  output logic [CSR_ADDR_W-1:0] o_wr_addr,
  output logic [XLEN-1:0]       o_wr_data,
  output logic [NUM_HARTS-1:0]  o_core_rst_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("arch_state_loader: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                r_state;
  state_e                w_next;
  logic [NUM_HARTS-1:0]  r_fp_en;
  logic [XLEN-1:0]       r_data;
  logic [CSR_ADDR_W-1:0] r_csr_addr;
  logic                  r_busy;
  logic                  r_done;
  logic [NUM_HARTS-1:0]  r_core_rst_n;

  logic                  w_start_ok;
  logic                  w_wr_fire;
  logic                  w_timeout;
  logic                  w_to_error;
  logic                  w_last;
  logic [HART_W-1:0]     w_hart;
  logic [IDX_W-1:0]      w_idx;
  wr_kind_e              w_kind;
  logic [CSR_ADDR_W-1:0] w_reg_num;

  assign w_start_ok = i_start &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_wr_fire  = (r_state == S_WRITE) && i_wr_ready;
  assign w_to_error = (r_state == S_WAIT || r_state == S_WRITE) && (w_next == S_ERROR);

  arch_loader_idx_seq #(
    .NUM_HARTS  (NUM_HARTS),
    .NUM_XPR    (NUM_XPR),
    .NUM_FPR    (NUM_FPR),
    .NUM_CSR    (NUM_CSR),
    .CSR_ADDR_W (CSR_ADDR_W)
  ) u_idx_seq (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_start_ok),
    .i_advance (w_wr_fire),
    .i_fp_en   (r_fp_en),
    .o_hart    (w_hart),
    .o_idx     (w_idx),
    .o_kind    (w_kind),
    .o_reg_num (w_reg_num),
    .o_last    (w_last)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_start) w_next = S_REQ;
      S_REQ:                   w_next = S_WAIT;
      S_WAIT: begin
        if (i_tbl_rsp_valid) w_next = S_WRITE;
        else if (w_timeout)  w_next = S_ERROR;
      end
      S_WRITE: begin
        if (i_wr_ready)     w_next = w_last ? S_DONE : S_REQ;
        else if (w_timeout) w_next = S_ERROR;
      end
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fp_en    <= '0;
      r_data     <= '0;
      r_csr_addr <= '0;
    end else begin
      if (w_start_ok) r_fp_en <= i_fp_en;
      if (r_state == S_WAIT && i_tbl_rsp_valid) begin
        r_data     <= i_tbl_rsp_data;
        r_csr_addr <= i_tbl_rsp_addr;
      end
    end
  end

  // Core resets only rise from DONE, one cycle after the last write lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_rst_n <= '0;
    end else if (w_start_ok) begin
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_core_rst_n <= '0;
    end else if (r_state == S_DONE && r_busy) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b1;
      r_core_rst_n <= '1;
    end else if (w_to_error) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b1;
    end
  end

`ifdef ARCH_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_wdog;
  logic            r_error;

  // Any state change restarts the count, so each WAIT/WRITE visit starts at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        r_wdog <= '0;
    else if (w_next != r_state)                        r_wdog <= '0;
    else if (r_state == S_WAIT || r_state == S_WRITE)  r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT || r_state == S_WRITE) &&
                     (r_wdog == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_error <= 1'b0;
    else if (w_start_ok) r_error <= 1'b0;
    else if (w_to_error) r_error <= 1'b1;
  end

  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif

  assign o_tbl_req_valid = (r_state == S_REQ);
  assign o_tbl_req_hart  = o_tbl_req_valid ? w_hart : '0;
  assign o_tbl_req_idx   = o_tbl_req_valid ? w_idx  : '0;

  assign o_wr_valid = (r_state == S_WRITE);
  assign o_wr_hart  = o_wr_valid ? w_hart : '0;
  assign o_wr_kind  = o_wr_valid ? w_kind : WR_XPR;
  assign o_wr_addr  = !o_wr_valid        ? '0 :
                      (w_kind == WR_CSR) ? r_csr_addr : w_reg_num;
  assign o_wr_data  = o_wr_valid ? r_data : '0;

  assign o_core_rst_n = r_core_rst_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
